// File: rtl/mem_access_unit.sv
// Load/store initiator between the datapath and a halfword-wide big-endian Data_Mem.
// Optional MAU_SIGN_EXT_EN: honour req_signed on byte loads (default: zero-extend all).
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic                byte_q, byte_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    // Holds store data from acceptance, then the load result or merged halfword from CAP on.
    logic [DATA_W-1:0]   data_q, data_d;

    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    logic                accept;
    logic [7:0]          lane;
    logic                ext_bit;

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign lane      = addr_q[0] ? read_data[7:0] : read_data[15:8];

`ifdef MAU_SIGN_EXT_EN
    assign ext_bit = signed_q & lane[7];
`else
    logic unused_signed;
    assign unused_signed = signed_q;
    assign ext_bit       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    data_d   = req_wdata;
                    if (!req_byte && req_addr[0])
                        state_d = S_ERR;
                    else if (req_write && !req_byte)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (!write_q) begin
                    data_d  = byte_q ? {{(DATA_W-8){ext_bit}}, lane} : read_data;
                    state_d = S_RESP;
                end else begin
                    data_d  = addr_q[0] ? {read_data[15:8], data_q[7:0]}
                                        : {data_q[7:0], read_data[7:0]};
                    state_d = S_WR;
                end
            end
            S_WR:   state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in that state.
        mem_read_d   = (state_d == S_RD);
        mem_write_d  = (state_d == S_WR);
        address_d    = (mem_read_d || mem_write_d) ? {addr_d[ADDR_W-1:1], 1'b0} : '0;
        write_data_d = mem_write_d ? data_d : '0;
        resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR);
        resp_err_d   = (state_d == S_ERR);
        resp_rdata_d = ((state_d == S_RESP) && !write_d) ? data_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign memRead    = mem_read_q;
    assign memWrite   = mem_write_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-level reference memory model, per-cycle
// compare of response and memory strobes, and literal pins on the model's results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] resp_rdata;
    logic        memRead;
    logic        memWrite;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data = '0;
    logic [2:0]  dbg_state;

`ifdef MAU_SIGN_EXT_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .memRead(memRead), .memWrite(memWrite), .address(address),
        .write_data(write_data), .read_data(read_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter / Data_Mem ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [15:0] dmem [0:32767];
    logic [7:0]  ref_mem [0:65535];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memRead)  read_data <= dmem[address[15:1]];
        if (memWrite) dmem[address[15:1]] <= write_data;
    end

    // ---------------- expectation queues ----------------
    typedef struct packed {
        int          cyc;
        logic        err;
        logic [15:0] rdata;
    } resp_t;

    typedef struct packed {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_t;

    resp_t exp_q[$];
    mem_t  mem_q[$];

    // Reference behaviour over a byte-addressed big-endian memory.
    function automatic void model(input logic w, input logic b, input logic s,
                                  input logic [15:0] a, input logic [15:0] wd,
                                  output logic err, output logic [15:0] rd,
                                  output logic [15:0] wrd, output int lat);
        int ha;
        logic [7:0] hi, lo, ln;
        ha  = int'(a) - int'(a) % 2;
        hi  = ref_mem[ha];
        lo  = ref_mem[ha + 1];
        ln  = (int'(a) % 2 == 1) ? lo : hi;
        err = 1'b0;
        rd  = 16'h0000;
        wrd = 16'h0000;
        lat = 0;
        if (!b && (int'(a) % 2 == 1)) begin
            err = 1'b1;
            lat = 1;
        end else if (!w) begin
            lat = 3;
            if (!b) rd = {hi, lo};
            else if (SIGN_EN && s && ln[7]) rd = {8'hFF, ln};
            else rd = {8'h00, ln};
        end else if (!b) begin
            lat = 2;
            wrd = wd;
        end else begin
            lat = 4;
            wrd = (int'(a) % 2 == 1) ? {hi, wd[7:0]} : {wd[7:0], lo};
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (memRead || memWrite || address != 0 || write_data != 0 || resp_valid ||
                resp_err || resp_rdata != 0 || req_ready) begin
                errors++;
                $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h rv=%b re=%b rdata=%h rdy=%b, required all 0",
                         memRead, memWrite, address, write_data, resp_valid, resp_err, resp_rdata, req_ready);
            end
        end else begin
            checks++;
            if (memRead && memWrite) begin
                errors++;
                $display("FAIL strobe_overlap: cycle %0d memRead and memWrite both high", cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                checks++;
                if (!resp_valid || resp_err !== exp_q[0].err || resp_rdata !== exp_q[0].rdata) begin
                    errors++;
                    $display("FAIL response: cycle %0d got valid=%b err=%b rdata=%h, required valid=1 err=%b rdata=%h",
                             cyc, resp_valid, resp_err, resp_rdata, exp_q[0].err, exp_q[0].rdata);
                end
                void'(exp_q.pop_front());
            end else begin
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_resp: cycle %0d resp_valid=%b, required 0", cyc, resp_valid);
                end
            end
            if (memRead || memWrite) begin
                checks++;
                if (mem_q.size() == 0 || mem_q[0].cyc != cyc || mem_q[0].wr != memWrite ||
                    mem_q[0].addr !== address || (memWrite && mem_q[0].data !== write_data)) begin
                    errors++;
                    $display("FAIL mem_access: cycle %0d got rd=%b wr=%b addr=%h wdata=%h, required %s",
                             cyc, memRead, memWrite, address, write_data,
                             (mem_q.size() == 0) ? "no access" : "queued access");
                end
                if (mem_q.size() > 0 && mem_q[0].cyc == cyc) void'(mem_q.pop_front());
            end else if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_access: cycle %0d got no strobe, required wr=%b addr=%h",
                         cyc, mem_q[0].wr, mem_q[0].addr);
                void'(mem_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] wd, input bit commit,
                         output int acc, output int lat,
                         output logic [15:0] m_rd, output logic [15:0] m_wr);
        logic        err;
        logic [15:0] al;
        model(w, b, s, a, wd, err, m_rd, m_wr, lat);
        al = {a[15:1], 1'b0};
        req_write  = w;
        req_byte   = b;
        req_signed = s;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        acc = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept_timeout: addr=%h got no req_ready in 20 cycles, required acceptance", a);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{acc + lat, err, m_rd});
        if (!err) begin
            if (w && b) begin
                mem_q.push_back('{acc + 1, 1'b0, al, 16'h0000});
                mem_q.push_back('{acc + 3, 1'b1, al, m_wr});
            end else if (w) begin
                mem_q.push_back('{acc + 1, 1'b1, al, m_wr});
            end else begin
                mem_q.push_back('{acc + 1, 1'b0, al, 16'h0000});
            end
            if (commit && w) begin
                ref_mem[int'(al)]     = m_wr[15:8];
                ref_mem[int'(al) + 1] = m_wr[7:0];
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses and %0d accesses outstanding, required 0",
                     exp_q.size(), mem_q.size());
            exp_q.delete();
            mem_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string nm, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // ---------------- main sequence ----------------
    int          acc_a, acc_b, lat_a, lat_b;
    logic [15:0] rd_m, wr_m;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            dmem[i]            = i[15:0];
            ref_mem[2 * i]     = i[15:8];
            ref_mem[2 * i + 1] = i[7:0];
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", {15'h0, req_ready}, 16'h0001);
        @(posedge clk);
        #1;

        issue(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("hw_load_0006", rd_m, 16'h0003);
        check_int("hw_load_latency", lat_a, 3);
        drain();

        issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("hw_store_wdata", wr_m, 16'hBEEF);
        check_int("hw_store_latency", lat_a, 2);
        drain();
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("hw_load_0010", rd_m, 16'hBEEF);
        drain();

        issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h11A5, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("byte_store_0021", wr_m, 16'h00A5);
        check_int("byte_store_latency", lat_a, 4);
        drain();
        issue(1'b1, 1'b1, 1'b0, 16'h0020, 16'h225A, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("byte_store_0020", wr_m, 16'h5AA5);
        drain();
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("hw_load_0020", rd_m, 16'h5AA5);
        drain();

        issue(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("signed_byte_0021", rd_m, SIGN_EN ? 16'hFFA5 : 16'h00A5);
        drain();
        issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("unsigned_byte_0020", rd_m, 16'h005A);
        drain();

        issue(1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_int("err_load_latency", lat_a, 1);
        drain();
        issue(1'b1, 1'b0, 1'b0, 16'h0007, 16'h1234, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_int("err_store_latency", lat_a, 1);
        drain();

        issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("byte_load_ffff", rd_m, 16'h00FF);
        drain();
        issue(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h003C, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("byte_store_ffff", wr_m, 16'h7F3C);
        drain();
        issue(1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("byte_load_fffe", rd_m, 16'h007F);
        drain();

        // req_valid stays high across both requests
        issue(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        issue(1'b1, 1'b0, 1'b0, 16'h0030, 16'hCAFE, 1'b1, acc_b, lat_b, rd_m, wr_m);
        check_int("back_to_back_accept", acc_b, acc_a + lat_a + 1);
        drain();

        // byte store abandoned by reset during CAP
        issue(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0099, 1'b0, acc_a, lat_a, rd_m, wr_m);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_abort", {15'h0, req_ready}, 16'h0001);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, acc_a, lat_a, rd_m, wr_m);
        check_val("hw_load_after_abort", rd_m, 16'h0020);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Load/store initiator between the MIPS datapath and `Data_Mem`.
- Accepts one halfword or byte request at a time over a valid/ready handshake and drives `memRead`, `memWrite`, `address` and `write_data` toward `Data_Mem`.
- Byte stores are done as read-modify-write, because `Data_Mem` writes full big-endian halfwords.
- Returns a single-cycle response pulse with the load data or an alignment error.

## Interface
- ADDR_W, 16, request and memory address width.
- DATA_W, 16, data width; fixed at 16 (halfword = 2 bytes, big-endian).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE with rst_n high.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = halfword access.
- req_signed  in  1  sign-extend byte loads (see Configuration).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; for byte stores only [7:0] is used.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid: misaligned halfword access.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- memRead  out  1  read strobe to `Data_Mem`.
- memWrite  out  1  write strobe to `Data_Mem`.
- address  out  ADDR_W  memory address; always even.
- write_data  out  DATA_W  memory write data.
- read_data  in  DATA_W  memory read data; valid the cycle after a memRead cycle.

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready.
  - All req_* fields are latched at acceptance.
  - Memory outputs depend only on state and latched fields; there is no combinational path from req_* inputs.
- Aligned address: aligned = {req_addr[ADDR_W-1:1], 1'b0}.
- Byte lane: big-endian. Address bit 0 = 0 selects the high byte [15:8]; bit 0 = 1 selects the low byte [7:0].
- States:
  - IDLE: req_ready=1.
    - On accept, a halfword access with req_addr[0]=1 goes to ERR.
    - A halfword store goes to WR.
    - Any other request goes to RD.
  - RD: memRead=1, address=aligned. Always goes to CAP.
  - CAP: read_data is valid here.
    - Load: register the result and go to RESP. Halfword loads return read_data; byte loads return the selected byte, extended to 16 bits.
    - Byte store: register the merged halfword (selected lane replaced by req_wdata[7:0], other lane kept) and go to WR.
  - WR: memWrite=1, address=aligned, write_data = req_wdata (halfword store) or the merged value (byte store). Goes to RESP.
  - RESP: resp_valid=1, resp_err=0, resp_rdata=result. Goes to IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory access. Goes to IDLE.
- Responses have no back-pressure.
- Address range is not checked; upper address bits pass through unchanged.
- Byte access at 0xFFFF uses aligned address 0xFFFE; no wrap beyond the halfword.
- memRead and memWrite are never high in the same cycle.

## Timing
- Cycle 0 is the acceptance cycle. resp_valid is asserted in:
  - halfword load: cycle 3
  - byte load: cycle 3
  - halfword store: cycle 2
  - byte store: cycle 4
  - error: cycle 1
- Throughput: next acceptance at the earliest in the cycle after RESP/ERR, since IDLE is re-entered.
- Reset (rst_n low) takes effect immediately:
  - state=IDLE
  - memRead, memWrite, address, write_data, resp_valid, resp_err, resp_rdata = 0
  - req_ready = 0
- Reset mid-operation abandons the request.
  - If reset hits before WR, no memWrite is ever issued.
  - No response is produced for an abandoned request.
- req_ready rises in the first cycle with rst_n high.

## Configuration
- MAU_SIGN_EXT_EN defined: byte loads with req_signed=1 are sign-extended from bit 7; byte loads with req_signed=0 are zero-extended.
- MAU_SIGN_EXT_EN undefined: req_signed is ignored and all byte loads are zero-extended.
- Halfword loads are unaffected either way.

## Test plan
- Halfword load 0x0006 on initialized memory -> exactly one memRead cycle with address 0x0006; resp_valid at cycle 3 with resp_rdata=0x0003, resp_err=0.
- Halfword store 0xBEEF to 0x0010, then halfword load 0x0010 -> store resp at cycle 2 (one memWrite cycle, write_data=0xBEEF); load returns 0xBEEF.
- Byte store 0xA5 to 0x0021, byte store 0x5A to 0x0020, then halfword load 0x0020 -> RD/WR at address 0x0020, write_data 0x00A5 then 0x5AA5; load returns 0x5AA5.
- With MAU_SIGN_EXT_EN, signed byte load of 0x0021 -> 0xFFA5; without the macro -> 0x00A5. Unsigned byte load of 0x0020 -> 0x005A.
- Halfword load or store at 0x0007 -> resp_valid and resp_err at cycle 1, resp_rdata=0, memRead and memWrite never asserted.
- Byte store, rst_n pulsed low during CAP -> memWrite never asserted, all outputs 0 during reset, req_ready=1 in the first cycle after release. Separately, with req_valid held high, the second request is accepted only in the cycle after RESP.
